// File: rtl/nco_sincos.sv
// ============================================================================
// Module   : nco_sincos
// Brief    : Phase-accumulator NCO with quarter-wave LUT, quadrature sin/cos.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nco_sincos #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 14,
  parameter int LUT_AW  = 10,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  input  logic [PHASE_W-1:0] phi_inc_i,
  output logic [OUT_W-1:0]   fsin_o,
  output logic [OUT_W-1:0]   fcos_o,
  output logic               out_valid
);

  localparam int c_PW    = LUT_AW + 2;
  localparam int c_LUT_N = 2 ** LUT_AW;
  localparam int c_AMP   = 2 ** (OUT_W - 1) - 1;
  localparam int c_CW    = $clog2(LATENCY + 1);

  localparam logic [c_CW-1:0]   c_CNT_MAX  = c_CW'(LATENCY);
  localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(LATENCY - 1);
  localparam logic [LUT_AW:0]   c_QTR_ADDR = (LUT_AW + 1)'(c_LUT_N);
  localparam logic [c_PW-1:0]   c_QTR_PH   = c_PW'(c_LUT_N);

  // Table contents are built at elaboration in 2^-60 fixed point so every
  // entry rounds exactly like round(AMP*sin(.)); pi comes from Machin's formula.
  typedef logic signed [127:0] wide_t;
  localparam wide_t c_ONE = wide_t'(1) <<< 60;

  function automatic wide_t f_atan_inv(input wide_t n);
    wide_t pw, sum, term;
    pw  = c_ONE / n;
    sum = pw;
    for (int k = 1; k < 40; k++) begin
      pw   = pw / (n * n);
      term = pw / wide_t'(2 * k + 1);
      sum  = (k % 2 == 1) ? sum - term : sum + term;
    end
    return sum;
  endfunction

  function automatic logic [OUT_W-2:0] f_lut(input wide_t j);
    wide_t pi, x, x2, term, s, r;
    pi   = wide_t'(16) * f_atan_inv(wide_t'(5)) - wide_t'(4) * f_atan_inv(wide_t'(239));
    x    = (pi * j) / wide_t'(2 * c_LUT_N);
    x2   = (x * x) >>> 60;
    term = x;
    s    = x;
    for (int n = 1; n < 16; n++) begin
      term = -((term * x2) >>> 60) / wide_t'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    r = (s * wide_t'(c_AMP) + (c_ONE >>> 1)) >>> 60;
    return r[OUT_W-2:0];
  endfunction

  // Odd quadrants walk the quarter wave backwards; k=0 there reads entry N.
  function automatic logic [LUT_AW:0] f_addr(input logic [c_PW-1:0] p);
    logic [LUT_AW:0] k;
    k = {1'b0, p[LUT_AW-1:0]};
    return p[LUT_AW] ? c_QTR_ADDR - k : k;
  endfunction

  logic [OUT_W-2:0] w_lut [0:c_LUT_N];

  for (genvar j = 0; j <= c_LUT_N; j++) begin : g_lut
    localparam logic [OUT_W-2:0] c_VAL = f_lut(wide_t'(j));
    assign w_lut[j] = c_VAL;
  end

  logic [PHASE_W-1:0] r_acc;
  logic [c_PW-1:0]    r_p;
  logic [LUT_AW:0]    r_s_addr, r_c_addr;
  logic               r_s_neg2, r_c_neg2;
  logic [OUT_W-2:0]   r_s_mag, r_c_mag;
  logic               r_s_neg3, r_c_neg3;
  logic [OUT_W-1:0]   r_sin, r_cos;
  logic [c_CW-1:0]    r_cnt;
  logic               r_valid;

  logic [c_PW-1:0]    w_p_cos;
  logic [OUT_W-1:0]   w_s_ext, w_c_ext;

  assign w_p_cos = r_p + c_QTR_PH;
  assign w_s_ext = {1'b0, r_s_mag};
  assign w_c_ext = {1'b0, r_c_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_p      <= '0;
      r_s_addr <= '0;
      r_c_addr <= '0;
      r_s_neg2 <= 1'b0;
      r_c_neg2 <= 1'b0;
      r_s_mag  <= '0;
      r_c_mag  <= '0;
      r_s_neg3 <= 1'b0;
      r_c_neg3 <= 1'b0;
      r_sin    <= '0;
      r_cos    <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
    end else if (clken) begin
      r_acc    <= r_acc + phi_inc_i;
      r_p      <= r_acc[PHASE_W-1 -: c_PW];
      r_s_addr <= f_addr(r_p);
      r_c_addr <= f_addr(w_p_cos);
      r_s_neg2 <= r_p[c_PW-1];
      r_c_neg2 <= w_p_cos[c_PW-1];
      r_s_mag  <= w_lut[r_s_addr];
      r_c_mag  <= w_lut[r_c_addr];
      r_s_neg3 <= r_s_neg2;
      r_c_neg3 <= r_c_neg2;
      r_sin    <= r_s_neg3 ? -w_s_ext : w_s_ext;
      r_cos    <= r_c_neg3 ? -w_c_ext : w_c_ext;
      if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_CNT_LAST) r_valid <= 1'b1;
    end
  end

  assign fsin_o    = r_sin;
  assign fcos_o    = r_cos;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_nco_sincos.sv
// ============================================================================
// Module   : tb_nco_sincos
// Brief    : Directed self-checking bench for nco_sincos.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nco_sincos;

  logic        clk;
  logic        reset;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic [13:0] fsin_o;
  logic [13:0] fcos_o;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  nco_sincos #(
    .PHASE_W (32),
    .OUT_W   (14),
    .LUT_AW  (10),
    .LATENCY (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic [13:0] s, input logic [13:0] c);
    chk({tag, ".sin"}, fsin_o, s);
    chk({tag, ".cos"}, fcos_o, c);
    chk({tag, ".valid"}, {13'd0, out_valid}, 14'd1);
  endtask

  task automatic chk_invalid(input string tag);
    chk({tag, ".valid"}, {13'd0, out_valid}, 14'd0);
  endtask

  initial begin
    reset     = 1'b1;
    clken     = 1'b1;
    phi_inc_i = 32'h4000_0000;

    // T1: held reset with clken high
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t1.rst.sin", fsin_o, 14'd0);
      chk("t1.rst.cos", fcos_o, 14'd0);
      chk_invalid("t1.rst");
    end

    // T2: quarter-turn increment
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_invalid("t2.fill");
    end
    for (int r = 0; r < 2; r++) begin
      step(); chk_pair("t2.p0",     14'sd0,     14'sd8191);
      step(); chk_pair("t2.p1024",  14'sd8191,  14'sd0);
      step(); chk_pair("t2.p2048",  14'sd0,    -14'sd8191);
      step(); chk_pair("t2.p3072", -14'sd8191,  14'sd0);
    end

    // T3/T4: odd increment, latency, then a 5-cycle freeze
    reset = 1'b1;
    step();
    chk_invalid("t3.rst");
    phi_inc_i = 32'h47AE_147B;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_invalid("t3.fill");
    end
    step();
    chk_pair("t3.first", 14'sd0, 14'sd8191);
    clken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_pair("t4.frozen", 14'sd0, 14'sd8191);
    end
    clken = 1'b1;
    step();
    chk_pair("t4.resume", 14'sd8048, -14'sd1524);

    // T5: negative increment, phase wraps backwards through zero
    reset = 1'b1;
    step();
    phi_inc_i = 32'hFFF0_0000;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_invalid("t5.fill");
    end
    step(); chk_pair("t5.p0",     14'sd0,   14'sd8191);
    step(); chk_pair("t5.p4095", -14'sd13,  14'sd8191);
    step(); chk_pair("t5.p4094", -14'sd25,  14'sd8191);
    step(); chk_pair("t5.p4093", -14'sd38,  14'sd8191);

    // T6: single-cycle reset mid-stream restarts at phase 0
    reset = 1'b1;
    step();
    chk("t6.rst.sin", fsin_o, 14'd0);
    chk("t6.rst.cos", fcos_o, 14'd0);
    chk_invalid("t6.rst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_invalid("t6.fill");
    end
    step(); chk_pair("t6.p0",     14'sd0,   14'sd8191);
    step(); chk_pair("t6.p4095", -14'sd13,  14'sd8191);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
